ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
- Parametrised instruction fetch stage with a DEPTH-entry instruction queue between icache/branch-predictor lookup and the decoder.
- Decouples fetch from decode with a valid/ready handshake. Fetch continues while decode stalls, until the queue fills.
- Handles ROB rollback by flushing the queue and redirecting the PC.
- Sits between icache, branch predictor, ROB and the decode unit.

Parameters:
- ADDR_W, 32, PC/address width
- INST_W, 32, instruction width
- DEPTH, 4, queue entries; power of two, at least 2
- PC_INC, 4, sequential PC increment
- RST_PC, 0, PC value after reset

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- rdy  in  1  global ready; low freezes all state
- if_en  in  1  fetch enable
- if_st  in  1  fetch stall (new requests only; decode side unaffected)
- if_rb  in  1  rollback request
- rb_pc  in  ADDR_W  rollback target PC
- cache_rd_en  out  1  icache read request
- cache_rd_addr  out  ADDR_W  icache read address (current pc)
- cache_hit  in  1  icache hit this cycle
- cache_hit_inst  in  INST_W  instruction on hit
- bp_pc  out  ADDR_W  predictor probe PC (current pc)
- bp_inst  out  INST_W  predictor probe instruction (cache_hit_inst)
- bp_pd_tk  in  1  predicted taken
- bp_pd_off  in  ADDR_W  predicted target offset
- dec_valid  out  1  queue head valid
- dec_ready  in  1  decoder accepts head
- dec_inst  out  INST_W  head instruction
- dec_cur_pc  out  ADDR_W  head PC
- dec_mis_pc  out  ADDR_W  head alternate (mispredict recovery) PC
- dec_pd_tk  out  1  head prediction
- q_count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset: rst is synchronous, active-high; clock clk. On rst: pc=RST_PC, head=tail=0, count=0. dec_valid=0, q_count=0. rst has priority over everything, including rdy low and if_rb; a reset mid-flight discards all queued entries.
- rdy=0: no register changes, dec_valid forced 0, cache_rd_en=0.
- full = (count==DEPTH). cache_rd_en = if_en & !if_st & !full & !if_rb & rdy.
- Push condition: cache_rd_en & cache_hit & (cache_hit_inst != 0). The entry written at tail is:
  - inst = cache_hit_inst
  - cur_pc = pc
  - pd_tk = bp_pd_tk
  - mis_pc = pd_tk ? pc+PC_INC : pc+bp_pd_off
- On push, pc <= pd_tk ? pc+bp_pd_off : pc+PC_INC. All PC arithmetic wraps modulo 2^ADDR_W.
- Pop condition: dec_valid & dec_ready. On pop, head advances.
- dec_* outputs are driven from the head entry (registered storage). dec_valid = (count!=0) & !if_rb & rdy.
- Latency: a pushed entry appears on dec_* the cycle after the push (1-cycle fetch-to-decode) when the queue was empty.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full: push is blocked even if a pop happens in the same cycle; it resumes the next cycle.
- Pointer wrap-around: pointers are log2(DEPTH) bits and wrap naturally. count disambiguates full from empty.
- Hit with inst==0 or no hit: no push, pc held, request repeats next cycle.
- if_st=1 or if_en=0: no requests and no pc advance. Pops continue.
- if_rb=1 (any if_en/if_st): pc <= rb_pc, head=tail=count=0. No push and no pop that cycle. dec_valid=0 that cycle.
- Rollback on the same cycle as a hit: the rollback wins and the hit is discarded.

Optional Feature:
- Macro IFQ_BYPASS_EN.
- Defined: when count==0, a push-eligible hit and dec_ready=1 (and no if_rb) presents the new entry on dec_* combinationally in the same cycle with dec_valid=1. The entry is consumed without being written; pointers and count stay unchanged, pc still advances. This gives 0-cycle fetch-to-decode latency.
- If dec_ready=0, the entry is enqueued normally.
- Undefined: no combinational path from icache/bp to dec_*. Latency is always 1 cycle.

Decomposition:
- Shared package/header: ADDR_W/INST_W defaults, ZERO_ADDR, NEXT_PC_INC, TRUE/FALSE, and the queue-entry field layout {inst, cur_pc, mis_pc, pd_tk} with its packed width.
- One sub-module, ifq_fifo: a generic DEPTH×entry synchronous FIFO with push/pop/flush, count, full/empty and head data.
- ifetch_queue keeps the PC register, request/push/bypass logic and next-PC computation.

Test Plan:
- Reset then 3 consecutive hits (bp_pd_tk=0, insts 0x13, 0x93, 0x113), dec_ready=1 -> dec_cur_pc 0x0, 0x4, 0x8 on consecutive cycles starting 1 cycle after the first hit; dec_mis_pc = pc+bp_pd_off.
- dec_ready=0, continuous hits, DEPTH=4 -> q_count reaches 4. cache_rd_en then drops, pc stays at 0x10. Raise dec_ready -> pops in order 0x0..0xC, fetch resumes from 0x10.
- Hit at pc=0x20 with bp_pd_tk=1, bp_pd_off=0xFFFFFFF0 -> next pc 0x10, entry mis_pc=0x24, dec_pd_tk=1.
- Queue holds 3 entries and if_rb=1 with rb_pc=0x100 on the same cycle as a hit -> count=0, dec_valid=0 that cycle, hit discarded, next request address 0x100.
- rdy=0 for 5 cycles with hits and dec_ready=1 -> pc, q_count and head unchanged. Assert rst mid-queue -> pc=RST_PC, q_count=0, dec_valid=0 next cycle.
- With IFQ_BYPASS_EN, empty queue, hit at 0x40, dec_ready=1 -> dec_valid=1 and dec_cur_pc=0x40 in the same cycle, q_count stays 0. Without it -> dec_valid asserts one cycle later.

Source files
------------

// File: rtl/ifetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue.
// Queue entry layout (MSB..LSB): {inst, cur_pc, mis_pc, pd_tk}.
// Optional same-cycle bypass to decode is enabled by defining IFQ_BYPASS_EN.
package ifetch_queue_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int INST_W_DEF = 32;

  localparam logic [31:0] ZERO_ADDR   = 32'h0000_0000;
  localparam logic [31:0] NEXT_PC_INC = 32'h0000_0004;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Packed width of one queue entry {inst, cur_pc, mis_pc, pd_tk}
  function automatic int ifq_entry_w(input int addr_w, input int inst_w);
    return inst_w + addr_w + addr_w + 1;
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with push/pop/flush.
// Storage is registered; the head entry is read out without a clock delay.
// A push while full and a pop while empty are ignored. rdy_i low freezes state.
module ifq_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 97
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_s, rd_s;

  assign full_o  = (count_q == CNT_MAX);
  assign empty_o = (count_q == {CNT_W{1'b0}});
  assign count_o = count_q;
  assign rdata_o = mem_q[head_q];

  // Pointer and occupancy next-state; reset and flush clear, rdy low holds
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    wr_s    = FALSE;
    rd_s    = FALSE;
    if (rst) begin
      head_d  = {PTR_W{1'b0}};
      tail_d  = {PTR_W{1'b0}};
      count_d = {CNT_W{1'b0}};
    end else if (!rdy_i) begin
      count_d = count_q;
    end else if (flush_i) begin
      head_d  = {PTR_W{1'b0}};
      tail_d  = {PTR_W{1'b0}};
      count_d = {CNT_W{1'b0}};
    end else begin
      wr_s   = push_i & ~full_o;
      rd_s   = pop_i & ~empty_o;
      tail_d = wr_s ? (tail_q + PTR_ONE) : tail_q;
      head_d = rd_s ? (head_q + PTR_ONE) : head_q;
      case ({wr_s, rd_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    head_q  <= head_d;
    tail_q  <= tail_d;
    count_q <= count_d;
  end

  // Entry storage; written at the tail on an accepted push
  always_ff @(posedge clk) begin
    if (wr_s && !rst) begin
      mem_q[tail_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: PC register, icache/predictor request, next-PC
// computation and a DEPTH-entry queue towards the decoder.
// Rollback flushes the queue and redirects the PC.
// Optional macro IFQ_BYPASS_EN: an eligible hit into an empty queue with the
// decoder ready is handed straight to decode in the same cycle.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int                ADDR_W = ADDR_W_DEF,
  parameter int                INST_W = INST_W_DEF,
  parameter int                DEPTH  = 4,
  parameter logic [ADDR_W-1:0] PC_INC = ADDR_W'(NEXT_PC_INC),
  parameter logic [ADDR_W-1:0] RST_PC = ADDR_W'(ZERO_ADDR)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   if_en,
  input  logic                   if_st,
  input  logic                   if_rb,
  input  logic [ADDR_W-1:0]      rb_pc,
  output logic                   cache_rd_en,
  output logic [ADDR_W-1:0]      cache_rd_addr,
  input  logic                   cache_hit,
  input  logic [INST_W-1:0]      cache_hit_inst,
  output logic [ADDR_W-1:0]      bp_pc,
  output logic [INST_W-1:0]      bp_inst,
  input  logic                   bp_pd_tk,
  input  logic [ADDR_W-1:0]      bp_pd_off,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  output logic [INST_W-1:0]      dec_inst,
  output logic [ADDR_W-1:0]      dec_cur_pc,
  output logic [ADDR_W-1:0]      dec_mis_pc,
  output logic                   dec_pd_tk,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int ENT_W = ifq_entry_w(ADDR_W, INST_W);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_inc_s, pc_tgt_s, mis_pc_s, next_pc_s;
  logic              full_s, empty_s;
  logic              hit_ok_s, bypass_s, push_s, pop_s, q_valid_s;
  logic [ENT_W-1:0]  new_ent_s, head_s;
  logic [INST_W-1:0] h_inst_s;
  logic [ADDR_W-1:0] h_cur_s, h_mis_s;
  logic              h_tk_s;

  assign cache_rd_en   = if_en & ~if_st & ~full_s & ~if_rb & rdy;
  assign cache_rd_addr = pc_q;
  assign bp_pc         = pc_q;
  assign bp_inst       = cache_hit_inst;

  // Taken branch: continue at target, recover at fall-through (and vice versa)
  assign pc_inc_s  = pc_q + PC_INC;
  assign pc_tgt_s  = pc_q + bp_pd_off;
  assign mis_pc_s  = bp_pd_tk ? pc_inc_s : pc_tgt_s;
  assign next_pc_s = bp_pd_tk ? pc_tgt_s : pc_inc_s;

  // A zero instruction word is treated as no usable hit
  assign hit_ok_s  = cache_rd_en & cache_hit & (cache_hit_inst != {INST_W{1'b0}});
  assign new_ent_s = {cache_hit_inst, pc_q, mis_pc_s, bp_pd_tk};

  assign q_valid_s = ~empty_s & ~if_rb & rdy;
  assign push_s    = hit_ok_s & ~bypass_s;
  assign pop_s     = q_valid_s & dec_ready;
  assign {h_inst_s, h_cur_s, h_mis_s, h_tk_s} = head_s;

`ifdef IFQ_BYPASS_EN
  // Same-cycle hand-off of a fresh hit when nothing is queued ahead of it
  always_comb begin
    bypass_s   = hit_ok_s & empty_s & dec_ready;
    dec_valid  = q_valid_s | bypass_s;
    dec_inst   = h_inst_s;
    dec_cur_pc = h_cur_s;
    dec_mis_pc = h_mis_s;
    dec_pd_tk  = h_tk_s;
    if (bypass_s) begin
      dec_inst   = cache_hit_inst;
      dec_cur_pc = pc_q;
      dec_mis_pc = mis_pc_s;
      dec_pd_tk  = bp_pd_tk;
    end else begin
      dec_pd_tk  = h_tk_s;
    end
  end
`else
  // Decode always sees the registered queue head
  always_comb begin
    bypass_s   = FALSE;
    dec_valid  = q_valid_s;
    dec_inst   = h_inst_s;
    dec_cur_pc = h_cur_s;
    dec_mis_pc = h_mis_s;
    dec_pd_tk  = h_tk_s;
  end
`endif

  // PC next-state: reset, freeze, rollback redirect, or advance on a usable hit
  always_comb begin
    pc_d = pc_q;
    if (rst) begin
      pc_d = RST_PC;
    end else if (!rdy) begin
      pc_d = pc_q;
    end else if (if_rb) begin
      pc_d = rb_pc;
    end else if (hit_ok_s) begin
      pc_d = next_pc_s;
    end else begin
      pc_d = pc_q;
    end
  end

  // PC register
  always_ff @(posedge clk) begin
    pc_q <= pc_d;
  end

  ifq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .rdy_i   (rdy),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .flush_i (if_rb),
    .wdata_i (new_ent_s),
    .rdata_o (head_s),
    .count_o (q_count),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios then random
// traffic, compared against a queue-based reference model.
// Build with or without IFQ_BYPASS_EN.
module tb_ifetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, rdy, if_en, if_st, if_rb;
  logic [31:0] rb_pc;
  logic        cache_rd_en;
  logic [31:0] cache_rd_addr;
  logic        cache_hit;
  logic [31:0] cache_hit_inst;
  logic [31:0] bp_pc, bp_inst;
  logic        bp_pd_tk;
  logic [31:0] bp_pd_off;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_inst, dec_cur_pc, dec_mis_pc;
  logic        dec_pd_tk;
  logic [2:0]  q_count;

  always #5 clk = ~clk;

  ifetch_queue dut (
    .clk(clk), .rst(rst), .rdy(rdy), .if_en(if_en), .if_st(if_st), .if_rb(if_rb),
    .rb_pc(rb_pc), .cache_rd_en(cache_rd_en), .cache_rd_addr(cache_rd_addr),
    .cache_hit(cache_hit), .cache_hit_inst(cache_hit_inst), .bp_pc(bp_pc),
    .bp_inst(bp_inst), .bp_pd_tk(bp_pd_tk), .bp_pd_off(bp_pd_off),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_inst(dec_inst),
    .dec_cur_pc(dec_cur_pc), .dec_mis_pc(dec_mis_pc), .dec_pd_tk(dec_pd_tk),
    .q_count(q_count)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] cur;
    logic [31:0] mis;
    logic        tk;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  int          n_assert = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    rdy = 1'b1; if_en = 1'b0; if_st = 1'b0; if_rb = 1'b0; rb_pc = 32'h0;
    cache_hit = 1'b0; cache_hit_inst = 32'h0; bp_pd_tk = 1'b0; bp_pd_off = 32'h0;
    dec_ready = 1'b0;
  endtask

  task automatic reset_dut();
    set_idle();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    mq.delete();
    m_pc = 32'h0;
  endtask

  // One clock: check outputs against the model, then advance the model.
  task automatic tick();
    logic exp_rd, hit, byp, exp_val;
    ent_t e, h;
    #2;
    exp_rd = rdy & if_en & ~if_st & ~if_rb & (mq.size() < DEPTH);
    hit    = exp_rd & cache_hit & (cache_hit_inst != 32'h0);
    byp    = 1'b0;
`ifdef IFQ_BYPASS_EN
    byp    = hit & (mq.size() == 0) & dec_ready;
`endif
    exp_val = rdy & ~if_rb & ((mq.size() != 0) | byp);
    e.inst = cache_hit_inst;
    e.cur  = m_pc;
    e.tk   = bp_pd_tk;
    e.mis  = bp_pd_tk ? (m_pc + 32'd4) : (m_pc + bp_pd_off);
    chk("cache_rd_en", cache_rd_en, exp_rd);
    chk("cache_rd_addr", cache_rd_addr, m_pc);
    chk("bp_pc", bp_pc, m_pc);
    chk("dec_valid", dec_valid, exp_val);
    chk("q_count", q_count, 64'(mq.size()));
    if (exp_val) begin
      h = byp ? e : mq[0];
      chk("dec_inst", dec_inst, h.inst);
      chk("dec_cur_pc", dec_cur_pc, h.cur);
      chk("dec_mis_pc", dec_mis_pc, h.mis);
      chk("dec_pd_tk", dec_pd_tk, h.tk);
    end
    if (rst) begin
      mq.delete();
      m_pc = 32'h0;
    end else if (rdy) begin
      if (if_rb) begin
        mq.delete();
        m_pc = rb_pc;
      end else begin
        if (exp_val && dec_ready && !byp) void'(mq.pop_front());
        if (hit) begin
          if (!byp) mq.push_back(e);
          m_pc = bp_pd_tk ? (m_pc + bp_pd_off) : (m_pc + 32'd4);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  logic [31:0] insts [3];

  initial begin
    insts[0] = 32'h13; insts[1] = 32'h93; insts[2] = 32'h113;

    // Reset state
    reset_dut();
    #1;
    chk("rst_dec_valid", dec_valid, 1'b0);
    chk("rst_q_count", q_count, 3'd0);
    chk("rst_pc", cache_rd_addr, 32'h0);

    // Three consecutive hits, decoder always ready
    if_en = 1'b1; dec_ready = 1'b1; cache_hit = 1'b1; bp_pd_off = 32'h40;
    for (int i = 0; i < 3; i++) begin
      cache_hit_inst = insts[i];
      tick();
      #1;
`ifndef IFQ_BYPASS_EN
      chk("seq_valid", dec_valid, 1'b1);
      chk("seq_cur_pc", dec_cur_pc, 64'(i * 4));
      chk("seq_mis_pc", dec_mis_pc, 64'(i * 4 + 32'h40));
`endif
    end
    cache_hit = 1'b0;
    tick();

    // Fill the queue with the decoder stalled, then drain in order
    reset_dut();
    if_en = 1'b1; cache_hit = 1'b1; bp_pd_off = 32'h8;
    for (int i = 0; i < 6; i++) begin
      cache_hit_inst = $urandom | 32'h1;
      tick();
    end
    #1;
    chk("full_count", q_count, 3'd4);
    chk("full_rd_en", cache_rd_en, 1'b0);
    chk("full_pc", cache_rd_addr, 32'h10);
    dec_ready = 1'b1; cache_hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_cur_pc", dec_cur_pc, 64'(i * 4));
      tick();
    end
    #1;
    chk("drain_count", q_count, 3'd0);
    chk("resume_rd_en", cache_rd_en, 1'b1);
    chk("resume_pc", cache_rd_addr, 32'h10);
    tick();

    // Predicted-taken branch with negative offset
    reset_dut();
    if_rb = 1'b1; rb_pc = 32'h20;
    tick();
    if_rb = 1'b0; if_en = 1'b1; cache_hit = 1'b1; cache_hit_inst = 32'h6f;
    bp_pd_tk = 1'b1; bp_pd_off = 32'hFFFF_FFF0;
    tick();
    cache_hit = 1'b0; bp_pd_tk = 1'b0;
    #1;
    chk("tk_next_pc", cache_rd_addr, 32'h10);
    chk("tk_valid", dec_valid, 1'b1);
    chk("tk_cur_pc", dec_cur_pc, 32'h20);
    chk("tk_mis_pc", dec_mis_pc, 32'h24);
    chk("tk_pd_tk", dec_pd_tk, 1'b1);
    tick();

    // Rollback coinciding with a hit while three entries are queued
    reset_dut();
    if_en = 1'b1; cache_hit = 1'b1; cache_hit_inst = 32'h33; bp_pd_off = 32'h8;
    for (int i = 0; i < 3; i++) tick();
    if_rb = 1'b1; rb_pc = 32'h100; dec_ready = 1'b1;
    #1;
    chk("rb_pre_count", q_count, 3'd3);
    chk("rb_valid", dec_valid, 1'b0);
    chk("rb_rd_en", cache_rd_en, 1'b0);
    tick();
    if_rb = 1'b0; cache_hit = 1'b0;
    #1;
    chk("rb_count", q_count, 3'd0);
    chk("rb_pc", cache_rd_addr, 32'h100);
    chk("rb_post_valid", dec_valid, 1'b0);
    tick();

    // rdy low freezes everything; then reset mid-queue
    reset_dut();
    if_en = 1'b1; cache_hit = 1'b1; cache_hit_inst = 32'h37;
    tick(); tick();
    rdy = 1'b0; dec_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rdy = 1'b1; dec_ready = 1'b0; cache_hit = 1'b0;
    #1;
    chk("frz_count", q_count, 3'd2);
    chk("frz_pc", cache_rd_addr, 32'h8);
    chk("frz_head", dec_cur_pc, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_pc", cache_rd_addr, 32'h0);
    chk("mid_rst_count", q_count, 3'd0);
    chk("mid_rst_valid", dec_valid, 1'b0);
    tick();

    // Empty-queue hit latency (bypass vs. registered)
    reset_dut();
    if_rb = 1'b1; rb_pc = 32'h40;
    tick();
    if_rb = 1'b0; if_en = 1'b1; cache_hit = 1'b1; cache_hit_inst = 32'h73;
    bp_pd_off = 32'h4; dec_ready = 1'b1;
    #1;
`ifdef IFQ_BYPASS_EN
    chk("byp_valid", dec_valid, 1'b1);
    chk("byp_cur_pc", dec_cur_pc, 32'h40);
    chk("byp_count", q_count, 3'd0);
`else
    chk("lat_valid0", dec_valid, 1'b0);
`endif
    tick();
    cache_hit = 1'b0;
    #1;
`ifdef IFQ_BYPASS_EN
    chk("byp_count_after", q_count, 3'd0);
    chk("byp_valid_after", dec_valid, 1'b0);
`else
    chk("lat_valid1", dec_valid, 1'b1);
    chk("lat_cur_pc", dec_cur_pc, 32'h40);
`endif
    tick();

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst            = ($urandom % 97) == 0;
      rdy            = ($urandom % 10) != 0;
      if_en          = ($urandom % 8) != 0;
      if_st          = ($urandom % 6) == 0;
      if_rb          = ($urandom % 20) == 0;
      rb_pc          = $urandom;
      cache_hit      = ($urandom % 4) != 0;
      cache_hit_inst = (($urandom % 5) == 0) ? 32'h0 : $urandom;
      bp_pd_tk       = ($urandom % 3) == 0;
      bp_pd_off      = $urandom;
      dec_ready      = ($urandom % 3) != 0;
      tick();
    end

    set_idle();
    rst = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
